// File: rtl/teller_dispatcher.sv
// Teller dispatcher: round-robin calls the queue head to a free, open teller window.
// Optional per-teller service timeout is enabled by defining TELLER_TIMEOUT_EN.
module teller_dispatcher #(
  parameter int unsigned NT          = 3,
  parameter int unsigned CALL_CYCLES = 4,
  parameter int unsigned TW          = 8,
  parameter int unsigned SVC_MAX     = 200
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [NT-1:0] teller_open,
  input  logic [NT-1:0] teller_done,
  input  logic          empty_flag,
  output logic          dequeue_n,
  output logic          call_valid,
  output logic [1:0]    call_teller,
  output logic [NT-1:0] busy,
  output logic [1:0]    tcount,
  output logic [NT-1:0] overtime
);

  localparam int unsigned CW = $clog2(CALL_CYCLES + 1);

  // Window count and the 2-bit tcount port only agree for three tellers.
  if (NT != 3 || CALL_CYCLES == 0 || SVC_MAX == 0 || SVC_MAX >= (1 << TW)) begin : g_cfg_check
    $error("teller_dispatcher: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, GRANT, CALL, SETTLE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    rr, rr_d;
  logic [1:0]    call_teller_d;
  logic          call_valid_d;
  logic          dequeue_n_d;
  logic [NT-1:0] grant_mask;
  logic [NT-1:0] busy_d;
  logic [NT-1:0] expire;
  logic [NT-1:0] elig;
  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic [2:0]    sum;

  assign tcount = (teller_open == '0) ? 2'd1
                : 2'(teller_open[0]) + 2'(teller_open[1]) + 2'(teller_open[2]);

  // Round-robin search starting at rr, wrapping modulo 3.
  always_comb begin
    elig  = teller_open & ~busy;
    found = 1'b0;
    win   = 2'd0;
    sum   = 3'd0;
    idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    rr_d          = rr;
    call_teller_d = call_teller;
    call_valid_d  = 1'b0;
    dequeue_n_d   = 1'b1;
    grant_mask    = '0;
    case (state)
      IDLE: begin
        if (!empty_flag && (elig != '0)) state_d = GRANT;
      end
      GRANT: begin
        if (found) begin
          dequeue_n_d     = 1'b0;
          call_teller_d   = win;
          grant_mask[win] = 1'b1;
          rr_d            = (win == 2'd2) ? 2'd0 : win + 2'd1;
          cnt_d           = '0;
          state_d         = CALL;
        end else begin
          state_d = IDLE;
        end
      end
      CALL: begin
        call_valid_d = 1'b1;
        if (cnt == CW'(CALL_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef TELLER_TIMEOUT_EN
  logic [TW-1:0] timer [NT];

  // A done pulse in the expiry cycle wins, so no overtime is reported.
  always_comb begin
    expire = '0;
    for (int i = 0; i < NT; i++) begin
      expire[i] = busy[i] && !teller_done[i] && (timer[i] == TW'(SVC_MAX - 1));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (Reset || grant_mask[i]) timer[i] <= '0;
      else if (busy[i])           timer[i] <= timer[i] + TW'(1);
    end
  end
`else
  assign expire = '0;
`endif

  assign busy_d = (busy & ~teller_done & ~expire) | grant_mask;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rr          <= 2'd0;
      call_teller <= 2'd0;
      call_valid  <= 1'b0;
      dequeue_n   <= 1'b1;
      busy        <= '0;
      overtime    <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rr          <= rr_d;
      call_teller <= call_teller_d;
      call_valid  <= call_valid_d;
      dequeue_n   <= dequeue_n_d;
      busy        <= busy_d;
      overtime    <= expire;
    end
  end

endmodule

// File: doc/teller_dispatcher.md
# teller_dispatcher

Teller dispatcher for the single-bank queue manager: tracks which of up to three teller windows are open and free, and calls the customer at the head of the queue to one free teller using round-robin arbitration. For each call it emits the active-low front-beam pulse that decrements the queue manager's person count. It also drives the queue manager's teller-count input, so the waiting-time estimate follows the open windows. Sits between the teller-desk button inputs and the queue manager on the same `clk`.

## Interface

**Parameters**
- `NT`, 3: number of teller windows; fixed at 3 to match the 2-bit `tcount`.
- `CALL_CYCLES`, 4: cycles `call_valid` stays high per call (display hold).
- `TW`, 8: width of the per-teller service timer.
- `SVC_MAX`, 200: service timeout in cycles; used only with `TELLER_TIMEOUT_EN`.

**Ports**
- `clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `teller_open`  in  NT  level; bit i set = window i staffed.
- `teller_done`  in  NT  one-cycle pulse; teller i finished its customer.
- `empty_flag`  in  1  from the queue manager; 1 = nobody waiting.
- `dequeue_n`  out  1  active-low one-cycle pulse; drives the queue manager's `down_count`.
- `call_valid`  out  1  high while a call is displayed.
- `call_teller`  out  2  index (0..2) of the window being called; valid while `call_valid` is high.
- `busy`  out  NT  bit i set = teller i is serving a customer.
- `tcount`  out  2  popcount of `teller_open`, clamped to a minimum of 1.
- `overtime`  out  NT  one-cycle pulse when teller i times out (timeout build only).

## Operation
- **Eligible teller:** `teller_open[i] & ~busy[i]`.
- **Round-robin:** pointer `rr` holds the index after the last grant. Search order is `rr`, `rr+1`, `rr+2` mod 3. The first eligible teller wins.
- **FSM states:** IDLE, GRANT, CALL, SETTLE.
- **IDLE → GRANT:** when `~empty_flag` and any teller is eligible.
- **GRANT (1 cycle):**
  - latch the winner into `call_teller`;
  - set `busy[winner]`;
  - drive `dequeue_n` low;
  - set `rr = winner+1 mod 3`.
- **CALL:** `call_valid` high for `CALL_CYCLES` cycles, then go to SETTLE.
- **SETTLE (1 cycle):** lets the queue manager update `empty_flag`. Then return to IDLE.
- **Teller release:**
  - `teller_done[i]` clears `busy[i]` in any state.
  - `teller_done` on a non-busy teller is ignored.
- **Closing a window:** deasserting `teller_open[i]` while `busy[i]` is set does not clear `busy[i]`. Teller i is simply not granted again.
- **Call duration:** `call_valid` and `call_teller` are held through CALL even if that teller's `teller_done` arrives mid-call.
- **`tcount` rule:** all closed → 1; otherwise the number of open windows (1..3). No grant occurs while all windows are closed.

## Timing
- **Reset values:**
  - `dequeue_n`=1, `call_valid`=0, `call_teller`=0, `busy`=0, `overtime`=0, `rr`=0;
  - state = IDLE;
  - `tcount` = f(`teller_open`), combinational.
- **Reset mid-call:** aborts the call; all `busy` bits are cleared next edge.
- **Grant latency:** IDLE condition true at edge N → `dequeue_n` low and `busy` set after edge N+1, for exactly one cycle.
- **Call window:** `call_valid` high from edge N+2 for `CALL_CYCLES` cycles.
- **Dispatch interval:** the earliest next grant is at edge N+3+`CALL_CYCLES` (about 1 grant per 7 cycles at default), so at most one dequeue per dispatch interval.
- **Same-cycle done and eligibility:** a `teller_done` at edge M makes that teller eligible from edge M+1. If it is the only eligible teller, it can win the grant evaluated at M+1.
- **Queue not empty but all tellers busy or closed:** stay in IDLE, `dequeue_n` held high.
- **`empty_flag` rising during CALL/SETTLE:** no effect; IDLE re-samples it.
- **`rr` wrap:** 2 → 0.

## Configuration
- **Macro:** `TELLER_TIMEOUT_EN`.
- **Defined:**
  - each teller has a `TW`-bit timer, cleared on grant and incrementing while `busy[i]`;
  - when the timer reaches `SVC_MAX`, `busy[i]` clears and `overtime[i]` pulses for one cycle;
  - if `teller_done[i]` arrives in the same cycle, it takes priority and no `overtime` pulse is issued.
- **Undefined:** no timers; `busy[i]` clears only on `teller_done[i]`; `overtime` is tied to 0.

## Test plan
- **Reset values:** Reset high 2 cycles with `teller_open`=000 → all outputs at reset values, `tcount`=1, no `dequeue_n` pulse while `empty_flag`=0.
- **Round-robin order:** `teller_open`=111, `empty_flag`=0 held → grants to tellers 0, 1, 2 at 7-cycle spacing, three one-cycle `dequeue_n` pulses, `busy`=111, then no further grants.
- **Release and reuse:** from `busy`=111, pulse `teller_done[1]` → next grant goes to teller 1, exactly 2 cycles after the done edge.
- **Closed window / tcount:** `teller_open`=101 → `tcount`=2; teller 1 never granted. Close teller 0 while busy → `busy[0]` stays set until `teller_done[0]`.
- **Empty queue / reset mid-call:** `empty_flag`=1 → no grants. Assert Reset during CALL → `call_valid`=0 and `busy`=000 after the next edge.
- **Timeout (`TELLER_TIMEOUT_EN`, `SVC_MAX`=10):** no done pulse → `overtime[i]` pulses 10 cycles after the grant and `busy[i]` clears. A simultaneous `teller_done` suppresses the `overtime` pulse.
